// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer: captures one packed complex FFT frame and streams it out
// one sample per valid/ready beat, in natural or bit-reversed order.
`default_nettype none

module fft_frame_serializer #(
  parameter int N_PTS  = 16,
  parameter int DW     = 32,
  parameter int BITREV = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_PTS*DW-1:0]   in_re,
  input  logic [N_PTS*DW-1:0]   in_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_re,
  output logic [DW-1:0]         out_im,
  output logic [$clog2(N_PTS)-1:0] out_idx,
  output logic                  out_last,
  output logic [15:0]           frames_done
);

  localparam int AW = $clog2(N_PTS);
  localparam logic [AW-1:0] LAST_CNT = AW'(N_PTS - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t              r_state;
  logic [AW-1:0]       r_cnt;
  logic [N_PTS*DW-1:0] r_frame_re;
  logic [N_PTS*DW-1:0] r_frame_im;

  logic          w_at_last;
  logic          w_capture;
  logic [AW-1:0] w_next_cnt;
  logic [AW-1:0] w_next_idx;

  function automatic logic [AW-1:0] map_idx(input logic [AW-1:0] c);
    logic [AW-1:0] r;
    r = c;
    if (BITREV != 0) begin
      for (int b = 0; b < AW; b++) r[b] = c[AW-1-b];
    end
    return r;
  endfunction

  assign w_at_last  = (r_state == STREAM) && (r_cnt == LAST_CNT);
  assign in_ready   = (r_state == IDLE) || (w_at_last && out_ready);
  assign w_capture  = in_valid && in_ready;
  assign w_next_cnt = r_cnt + AW'(1);
  assign w_next_idx = map_idx(w_next_cnt);

  // Element 0 maps to index 0 in both orders, so a capture always presents slice 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_frame_re  <= '0;
      r_frame_im  <= '0;
      frames_done <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_re      <= '0;
      out_im      <= '0;
      out_idx     <= '0;
    end else begin
      if (w_capture) begin
        r_state    <= STREAM;
        r_cnt      <= '0;
        r_frame_re <= in_re;
        r_frame_im <= in_im;
        out_valid  <= 1'b1;
        out_last   <= 1'b0;
        out_re     <= in_re[DW-1:0];
        out_im     <= in_im[DW-1:0];
        out_idx    <= '0;
      end
      if ((r_state == STREAM) && out_ready) begin
        if (r_cnt == LAST_CNT) begin
          frames_done <= frames_done + 16'd1;
          if (!in_valid) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end else begin
          r_cnt    <= w_next_cnt;
          out_idx  <= w_next_idx;
          out_re   <= r_frame_re[DW*int'(w_next_idx) +: DW];
          out_im   <= r_frame_im[DW*int'(w_next_idx) +: DW];
          out_last <= (w_next_cnt == LAST_CNT);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/fft_frame_serializer.md
Name: fft_frame_serializer

Overview:
- Output-side reader for the eightpt FFT core.
- Captures one packed frame of N_PTS complex results (real bus plus imaginary bus, each N_PTS*DW bits) in a single handshake.
- Streams the frame out one complex sample per beat over a valid/ready interface, in natural or bit-reversed order.
- Sits between the combinational FFT core and downstream sample consumers (DMA, magnitude unit, UART dump).

Parameters:
- N_PTS, 16, points per frame; power of two, at least 2.
- DW, 32, bits per real or imaginary word (signed 16.16 fixed point, passed through untouched).
- BITREV, 0, 0 = natural order; 1 = beat k outputs the element at bit-reversed index of k (log2(N_PTS) bits).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  frame present on in_re/in_im
- in_ready  out  1  frame is captured on in_valid && in_ready
- in_re  in  N_PTS*DW  real parts; element k at bits [DW*k+DW-1 : DW*k]
- in_im  in  N_PTS*DW  imaginary parts; same packing as in_re
- out_valid  out  1  sample beat valid
- out_ready  in  1  downstream accepts the beat
- out_re  out  DW  real part of current sample
- out_im  out  DW  imaginary part of current sample
- out_idx  out  log2(N_PTS)  source element index of current sample
- out_last  out  1  high on the final beat of a frame
- frames_done  out  16  count of fully streamed frames; wraps at 0xFFFF to 0

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state (asynchronous):
  - FSM = IDLE; beat counter = 0; frame buffer = 0; frames_done = 0.
  - out_valid = 0; out_last = 0; out_re/out_im/out_idx = 0.
  - in_ready = 1 once out of reset (it is combinational from state).
- States:
  - IDLE: in_ready = 1, out_valid = 0. When in_valid = 1, latch in_re/in_im into the frame buffer, clear the beat counter, go to STREAM.
  - STREAM: out_valid = 1. Present element idx(cnt); idx = cnt when BITREV = 0, else bitrev(cnt).
- Latency: first beat (out_valid = 1) appears in the cycle after the capture edge.
- Beat accept is out_valid && out_ready:
  - When cnt < N_PTS-1: cnt increments.
  - When cnt = N_PTS-1: frames_done increments. If in_valid is high in the same cycle, capture the new frame, cnt = 0, stay in STREAM (zero-bubble back-to-back). Otherwise go to IDLE.
- in_ready = (state == IDLE) || (state == STREAM && cnt == N_PTS-1 && out_ready). This is the only combinational input-to-output path.
- out_last = (state == STREAM) && (cnt == N_PTS-1).
- While out_valid && !out_ready, out_re/out_im/out_idx/out_last hold stable; cnt does not move.
- The frame buffer is written only on capture. Input bus changes during STREAM have no effect.
- in_valid while in STREAM with cnt < N_PTS-1: ignored (in_ready = 0). The upstream must hold in_valid.
- Reset asserted mid-frame: the partial frame is discarded, no frames_done increment; outputs return to reset values immediately.
- Each element index uses the same slice on both in_re and in_im. Real and imaginary parts must never be taken from different indices.
- Pure data movement: no arithmetic on samples; widths are preserved exactly.

Test Plan:
- Basic frame, BITREV = 0:
  - Stimulus: in_re element0 = 0x0011_0000, element1 = 0x1000_0000, all else 0; in_im = 0; out_ready tied 1.
  - Required: 16 consecutive beats starting one cycle after capture. Beat0 re = 0x0011_0000, beat1 re = 0x1000_0000, beats 2–15 = 0. out_idx = 0..15; out_last only on beat15; frames_done = 1; return to IDLE.
- Imaginary slice integrity:
  - Stimulus: in_im element k = 0xA000_0000 + k; in_re element k = k.
  - Required: every beat shows out_im = 0xA000_0000 + out_idx and out_re = out_idx. Explicitly check idx 11 = 0xA000_000B.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1,… pseudo-randomly.
  - Required: data is stable while stalled; no sample is dropped or duplicated; beat order is unchanged; exactly 16 accepts per frame.
- Back-to-back frames:
  - Stimulus: in_valid held high with frame B present while frame A is streaming.
  - Required: in_ready pulses only on A's last accepted beat. B's beat0 follows A's beat15 with no idle cycle. frames_done = 2.
- BITREV = 1:
  - Stimulus: element k real part = k.
  - Required: beat sequence out_re/out_idx = 0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15.
- Reset mid-frame:
  - Stimulus: assert rst_n = 0 after beat 5.
  - Required: out_valid drops asynchronously; frames_done = 0. After release, in_ready = 1 and a fresh frame streams from beat0.
